// File: rtl/alu_cmd_queue.sv
// Command queue in front of a combinational alu.
// Buffers {op,a,b} commands in a small FIFO and presents the head entry to the
// alu. The alu's result and zero flag are captured into a registered output
// stage that uses a valid/ready handshake. The queue sustains one op per cycle.
module alu_cmd_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic [2:0]               in_op,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [2:0]               alu_op,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic                     alu_zero,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic                     out_zero,
  output logic [2:0]               out_op,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 3 + 2 * WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [EW-1:0] head;
  logic          not_empty;
  logic          push;
  logic          pop;

  // Ready depends only on the registered occupancy, so a pop in the same cycle
  // never opens a combinational path from out_ready to in_ready.
  assign in_ready  = rst_n && (count < DEPTH_C);
  assign not_empty = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = not_empty && (!out_valid || out_ready);

  // Head entry is driven to the alu; an empty queue drives all zeros (op ADD).
  always_comb begin
    head = '0;
    if (not_empty) begin
      head = mem[rd_ptr];
    end
  end

  assign alu_op = head[EW-1 -: 3];
  assign alu_a  = head[2*WIDTH-1 -: WIDTH];
  assign alu_b  = head[WIDTH-1:0];

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_op, in_a, in_b};
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Output stage: capture the alu result on pop, drop valid when consumed
  // with nothing new to load; data registers hold their last value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_op     <= '0;
    end else if (pop) begin
      out_valid  <= 1'b1;
      out_result <= alu_result;
      out_zero   <= alu_zero;
      out_op     <= alu_op;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Self-checking bench for alu_cmd_queue driving a behavioural alu.
// Accepted commands push their expected {op,result,zero} into a scoreboard;
// independent monitor processes check results, hold stability and occupancy.
module tb_alu_cmd_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] in_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_zero;
  logic [2:0] out_op;
  logic [2:0] count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  alu_cmd_queue #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_op(out_op),
    .count(count)
  );

  // Operation semantics of the attached alu, written as plain arithmetic.
  function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int sa;
    int sb;
    sa = (a >= 8'd128) ? int'(a) - 256 : int'(a);
    sb = (b >= 8'd128) ? int'(b) - 256 : int'(b);
    case (op)
      3'd0:    return 8'((int'(a) + int'(b)) % 256);
      3'd1:    return 8'((int'(a) - int'(b) + 256) % 256);
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return 8'((int'(a) * 2) % 256);
      3'd6:    return 8'(int'(a) / 2);
      default: return (sa < sb) ? 8'd1 : 8'd0;
    endcase
  endfunction

  // Behavioural alu attached to the queue head.
  always_comb begin
    alu_result = alu_ref(alu_op, alu_a, alu_b);
    alu_zero   = (alu_result == 8'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive at +2 after the edge, observe acceptance at +7.
  task automatic cyc(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic rdy, output logic acc);
    logic [7:0] r;
    @(posedge clk);
    #2;
    in_valid  = v;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    out_ready = rdy;
    #5;
    acc = in_valid && in_ready;
    if (acc) begin
      r = alu_ref(op, a, b);
      exp_q.push_back({op, r, (r == 8'd0)});
    end
  endtask

  task automatic idle(input logic rdy);
    logic acc;
    cyc(1'b0, 3'd0, 8'd0, 8'd0, rdy, acc);
  endtask

  // Hold reset for n edges while offering a command; returns at +2 after release.
  task automatic do_reset(input int n);
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_op     = 3'($urandom_range(0, 7));
    in_a      = 8'($urandom);
    in_b      = 8'($urandom);
    out_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    exp_q.delete();
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  // Occupancy and ready check: FIFO holds every outstanding command except the one in the output stage.
  initial begin
    int occ;
    forever begin
      @(posedge clk);
      #6;
      if (!rst_n) begin
        chk("in_ready_in_reset", 32'(in_ready), 32'd0);
      end else begin
        occ = exp_q.size() - int'(out_valid);
        chk("count", 32'(count), 32'(occ));
        chk("in_ready", 32'(in_ready), 32'(occ < 4));
      end
    end
  end

  // Result monitor: pop and compare on each handshake, check stability under backpressure.
  initial begin
    logic        hold;
    logic [11:0] saved;
    logic [11:0] e;
    hold = 1'b0;
    saved = '0;
    forever begin
      @(posedge clk);
      #8;
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_data", 32'({out_op, out_result, out_zero}), 32'(saved));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_result: got %0h expected none at %0t",
                     {out_op, out_result, out_zero}, $time);
          end else begin
            e = exp_q.pop_front();
            chk("result", 32'({out_op, out_result, out_zero}), 32'(e));
          end
        end
        hold  = out_valid && !out_ready;
        saved = {out_op, out_result, out_zero};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic acc;
    int   k;
    logic [2:0] ops[6];
    logic [7:0] as[6];
    logic [7:0] bs[6];

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_op = '0;
    out_ready = 1'b0;

    // Reset with a command offered: nothing is accepted.
    do_reset(2);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_result", 32'(out_result), 32'd0);
    chk("rst_out_op", 32'(out_op), 32'd0);
    chk("rst_out_zero", 32'(out_zero), 32'd0);

    // Single ADD: two-cycle latency from accept to out_valid.
    cyc(1'b1, 3'd0, 8'h05, 8'h03, 1'b1, acc);
    chk("add_accept", 32'(acc), 32'd1);
    idle(1'b1);
    chk("lat_c1_valid", 32'(out_valid), 32'd0);
    chk("lat_c1_count", 32'(count), 32'd1);
    idle(1'b1);
    chk("lat_c2_valid", 32'(out_valid), 32'd1);
    chk("lat_c2_result", 32'(out_result), 32'h08);
    chk("lat_c2_count", 32'(count), 32'd0);
    idle(1'b1);

    // SUB giving zero, then SLT, on consecutive cycles.
    cyc(1'b1, 3'd1, 8'h07, 8'h07, 1'b1, acc);
    cyc(1'b1, 3'd7, 8'h03, 8'h05, 1'b1, acc);
    idle(1'b1);
    chk("sub_valid", 32'(out_valid), 32'd1);
    chk("sub_result", 32'({out_result, out_zero}), 32'h001);
    idle(1'b1);
    chk("slt_valid", 32'(out_valid), 32'd1);
    chk("slt_result", 32'({out_op, out_result, out_zero}), 32'({3'd7, 8'h01, 1'b0}));
    idle(1'b1);
    idle(1'b1);

    // Backpressure: six offered, five fit (four in FIFO plus output stage).
    for (int i = 0; i < 6; i++) begin
      ops[i] = 3'($urandom_range(0, 7));
      as[i]  = 8'($urandom);
      bs[i]  = 8'($urandom);
    end
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (k < 6) begin
        cyc(1'b1, ops[k], as[k], bs[k], 1'b0, acc);
        if (acc) k++;
      end
    end
    idle(1'b0);
    chk("bp_accepted", 32'(k), 32'd5);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_count", 32'(count), 32'd4);
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      chk("bp_drain_valid", 32'(out_valid), 32'd1);
    end
    idle(1'b1);
    chk("bp_drain_done", 32'(out_valid), 32'd0);

    // Back-to-back stream across pointer wrap.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b1, acc);
      chk("b2b_accept", 32'(acc), 32'd1);
      chk("b2b_count_le1", 32'(count <= 3'd1), 32'd1);
      if (i >= 2) chk("b2b_valid", 32'(out_valid), 32'd1);
    end
    repeat (3) idle(1'b1);

    // Reset with queued commands and a held result.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b0, acc);
    end
    idle(1'b0);
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    do_reset(1);
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      chk("post_rst_no_valid", 32'(out_valid), 32'd0);
    end

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
          1'($urandom_range(0, 2) != 0), acc);
    end
    for (int i = 0; i < 30; i++) begin
      if (exp_q.size() != 0 || out_valid) idle(1'b1);
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
